io_char_fifo: RTL

IO_CHAR_FIFO -- requirements
Module: io_char_fifo

---
 rtl/io_char_fifo_pkg.sv | 36 +++
 rtl/io_char_fifo_if.sv | 34 +++
 rtl/io_char_fifo_fifo_sync.sv | 65 ++++++
 rtl/io_char_fifo.sv | 103 ++++++++++
 4 files changed

// File: rtl/io_char_fifo_pkg.sv
// ============================================================================
// Module   : io_char_fifo_pkg
// Purpose  : Shared I/O port addresses and status-byte layout for io_char_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

package io_char_fifo_pkg;

    localparam logic [7:0] C_PORT_DATA  = 8'hA0;
    localparam logic [7:0] C_PORT_STAT  = 8'hA1;
    localparam logic [7:0] C_LINE_FEED  = 8'h0A;

    localparam int C_STAT_FULL_BIT  = 7;
    localparam int C_STAT_EMPTY_BIT = 6;
    localparam int C_STAT_OVF_BIT   = 5;
    localparam int C_STAT_CNT_W     = 5;

    function automatic logic [7:0] pack_status(
        input logic                    full,
        input logic                    empty,
        input logic                    ovf,
        input logic [C_STAT_CNT_W-1:0] cnt
    );
        logic [7:0] s;
        s                         = '0;
        s[C_STAT_FULL_BIT]        = full;
        s[C_STAT_EMPTY_BIT]       = empty;
        s[C_STAT_OVF_BIT]         = ovf;
        s[C_STAT_CNT_W-1:0]       = cnt;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/io_char_fifo_if.sv
// ============================================================================
// Module   : io_char_fifo_if
// Purpose  : CPU I/O bus plus character output stream of io_char_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface io_char_fifo_if;

    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr;
    logic [7:0] DO;
    logic [7:0] di_data;
    logic       di_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       line_done;

    modport master (
        output iorq_n, rd_n, wr_n, addr, DO, tx_ready,
        input  di_data, di_oe, tx_data, tx_valid, line_done
    );

    modport slave (
        input  iorq_n, rd_n, wr_n, addr, DO, tx_ready,
        output di_data, di_oe, tx_data, tx_valid, line_done
    );

endinterface

`default_nettype wire

// File: rtl/io_char_fifo_fifo_sync.sv
// ============================================================================
// Module   : fifo_sync
// Purpose  : Show-ahead synchronous FIFO storage with wrapping pointers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fifo_sync #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign dout  = r_mem[r_rptr];
    assign count = r_count;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_char_fifo.sv
// ============================================================================
// Module   : io_char_fifo
// Purpose  : CPU I/O-port character FIFO with status port and line-done pulse.
// Revision : 1.0
// ============================================================================
`default_nettype none

module io_char_fifo
    import io_char_fifo_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] PORT_DATA = C_PORT_DATA,
    parameter logic [7:0] PORT_STAT = C_PORT_STAT
) (
    input  wire logic     clk,
    input  wire logic     reset,
    io_char_fifo_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_last_wr;
    logic          r_armed;
    logic [7:0]    r_cap_addr;
    logic [7:0]    r_cap_data;
    logic          r_overflow;
    logic          r_line_done;

    logic          w_wr_stb;
    logic          w_commit;
    logic          w_hit_data;
    logic          w_hit_stat;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_dout;
    logic [CW-1:0] w_count;
    logic [C_STAT_CNT_W-1:0] w_cnt5;
    logic          w_di_oe;

    assign w_wr_stb   = ~bus.iorq_n & ~bus.wr_n;
    assign w_commit   = ~w_wr_stb & r_last_wr;
    assign w_hit_data = w_commit & (r_cap_addr == PORT_DATA);
    assign w_hit_stat = w_commit & (r_cap_addr == PORT_STAT);
    assign w_push     = w_hit_data & ~w_full;
    assign w_pop      = ~w_empty & bus.tx_ready;

    fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_cap_data),
        .dout  (w_dout),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // r_armed blocks a strobe that was already active across reset release
    // from producing a commit; the bus must first be seen idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_wr   <= 1'b0;
            r_armed     <= 1'b0;
            r_cap_addr  <= 8'h00;
            r_cap_data  <= 8'h00;
            r_overflow  <= 1'b0;
            r_line_done <= 1'b0;
        end else begin
            r_armed   <= r_armed | ~w_wr_stb;
            r_last_wr <= w_wr_stb & r_armed;
            if (w_wr_stb) begin
                r_cap_addr <= bus.addr;
                r_cap_data <= bus.DO;
            end
            if (w_hit_data & w_full) begin
                r_overflow <= 1'b1;
            end else if (w_hit_stat) begin
                r_overflow <= 1'b0;
            end
            r_line_done <= w_pop & (w_dout == C_LINE_FEED);
        end
    end

    assign w_cnt5  = C_STAT_CNT_W'(w_count);
    assign w_di_oe = ~bus.iorq_n & ~bus.rd_n & (bus.addr == PORT_STAT);

    assign bus.di_oe     = w_di_oe;
    assign bus.di_data   = (w_di_oe & ~reset)
                         ? pack_status(w_full, w_empty, r_overflow, w_cnt5)
                         : 8'h00;
    assign bus.tx_data   = w_dout;
    assign bus.tx_valid  = ~w_empty;
    assign bus.line_done = r_line_done;

endmodule

`default_nettype wire
